// File: rtl/keypad_emulator_if.sv
// Key request handshake between a key source and the keypad emulator.
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: plays each accepted key as bounce/hold/bounce/gap and
// answers the scanner's active-low column drive with registered active-low rows.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 300_000,
  parameter int unsigned BOUNCE_CYCLES = 2_000,
  parameter int unsigned BOUNCE_TOGGLE = 250,
  parameter int unsigned GAP_CYCLES    = 100_000
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  keypad_emulator_if.slave   key_if,
  input  logic [3:0]         col,
  output logic [3:0]         row,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_PRESS,
    S_HOLD,
    S_BOUNCE_REL,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ph_q, ph_d;
  logic        contact_q, contact_d;
  logic [1:0]  kcol_q, kcol_d;
  logic [1:0]  krow_q, krow_d;
  logic [3:0]  row_q, row_d;
  logic        done_q, done_d;
  logic [1:0]  code_col, code_row;

  // Legend -> (column, row) position on the physical pad.
  always_comb begin
    unique case (key_if.key_code)
      4'h1: {code_col, code_row} = {2'd0, 2'd0};
      4'h4: {code_col, code_row} = {2'd0, 2'd1};
      4'h7: {code_col, code_row} = {2'd0, 2'd2};
      4'h0: {code_col, code_row} = {2'd0, 2'd3};
      4'h2: {code_col, code_row} = {2'd1, 2'd0};
      4'h5: {code_col, code_row} = {2'd1, 2'd1};
      4'h8: {code_col, code_row} = {2'd1, 2'd2};
      4'hF: {code_col, code_row} = {2'd1, 2'd3};
      4'h3: {code_col, code_row} = {2'd2, 2'd0};
      4'h6: {code_col, code_row} = {2'd2, 2'd1};
      4'h9: {code_col, code_row} = {2'd2, 2'd2};
      4'hE: {code_col, code_row} = {2'd2, 2'd3};
      4'hA: {code_col, code_row} = {2'd3, 2'd0};
      4'hB: {code_col, code_row} = {2'd3, 2'd1};
      4'hC: {code_col, code_row} = {2'd3, 2'd2};
      4'hD: {code_col, code_row} = {2'd3, 2'd3};
      default: {code_col, code_row} = 4'b0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    ph_d      = ph_q;
    contact_d = contact_q;
    kcol_d    = kcol_q;
    krow_d    = krow_q;
    done_d    = 1'b0;

    if (state_q == S_BOUNCE_PRESS || state_q == S_BOUNCE_REL) begin
      if (ph_q == BOUNCE_TOGGLE - 32'd1) begin
        ph_d      = 32'd0;
        contact_d = ~contact_q;
      end else begin
        ph_d = ph_q + 32'd1;
      end
    end

    // Phase exits below override the bounce toggle with the next phase's contact level.
    case (state_q)
      S_IDLE: begin
        cnt_d     = 32'd0;
        contact_d = 1'b0;
        if (key_if.key_valid) begin
          kcol_d    = code_col;
          krow_d    = code_row;
          state_d   = (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE_PRESS;
          contact_d = 1'b1;
          ph_d      = 32'd0;
        end
      end
      S_BOUNCE_PRESS: begin
        if (cnt_q + 32'd1 >= BOUNCE_CYCLES) begin
          state_d   = S_HOLD;
          cnt_d     = 32'd0;
          contact_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q + 32'd1 >= HOLD_CYCLES) begin
          state_d   = (BOUNCE_CYCLES == 0) ? S_GAP : S_BOUNCE_REL;
          cnt_d     = 32'd0;
          contact_d = 1'b0;
          ph_d      = 32'd0;
        end
      end
      S_BOUNCE_REL: begin
        if (cnt_q + 32'd1 >= BOUNCE_CYCLES) begin
          state_d   = S_GAP;
          cnt_d     = 32'd0;
          contact_d = 1'b0;
        end
      end
      S_GAP: begin
        if (cnt_q + 32'd1 >= GAP_CYCLES) begin
          state_d   = S_IDLE;
          cnt_d     = 32'd0;
          contact_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = 32'd0;
        contact_d = 1'b0;
      end
    endcase

    row_d = (contact_q && !col[2'd3 - kcol_q]) ? ~(4'b1000 >> krow_q) : 4'b1111;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      ph_q      <= 32'd0;
      contact_q <= 1'b0;
      kcol_q    <= 2'd0;
      krow_q    <= 2'd0;
      row_q     <= 4'b1111;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      contact_q <= contact_d;
      kcol_q    <= kcol_d;
      krow_q    <= krow_d;
      row_q     <= row_d;
      done_q    <= done_d;
    end
  end

  assign key_if.key_ready = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign row              = row_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: dut 0 with bounce phases, dut 1 with bounce disabled.
module tb_keypad_emulator;

  localparam int H = 20;
  localparam int T = 2;
  localparam int G = 5;
  localparam int B0 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic       kv [2];
  logic [3:0] kc [2];
  logic [3:0] col_r [2];
  logic       kr [2];
  logic [3:0] row_w [2];
  logic       busy_w [2];
  logic       done_w [2];

  keypad_emulator_if if0 ();
  keypad_emulator_if if1 ();
  assign if0.key_valid = kv[0];
  assign if0.key_code  = kc[0];
  assign kr[0]         = if0.key_ready;
  assign if1.key_valid = kv[1];
  assign if1.key_code  = kc[1];
  assign kr[1]         = if1.key_ready;

  keypad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(B0), .BOUNCE_TOGGLE(T), .GAP_CYCLES(G)) dut0 (
    .clk_100MHz(clk), .reset(rst[0]), .key_if(if0.slave), .col(col_r[0]),
    .row(row_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  keypad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(T), .GAP_CYCLES(G)) dut1 (
    .clk_100MHz(clk), .reset(rst[1]), .key_if(if1.slave), .col(col_r[1]),
    .row(row_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legend table as printed on the pad: legend[column][row].
  function automatic logic [3:0] model_row(input logic [3:0] code, input logic [3:0] c,
                                           input bit contact);
    int legend [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};
    logic [3:0] r = 4'b1111;
    for (int ci = 0; ci < 4; ci++)
      for (int ri = 0; ri < 4; ri++)
        if (legend[ci][ri] == int'(code) && contact && c[3-ci] == 1'b0) r[3-ri] = 1'b0;
    return r;
  endfunction

  // Contact level in the i-th busy cycle after acceptance.
  function automatic bit model_contact(input int i, input int b);
    if (i < b) return ((i / T) % 2) == 0;
    if (i < b + H) return 1'b1;
    if (i < 2 * b + H) return ((i - b - H) / T) % 2 == 1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input int d);
    int guard = 0;
    while (!kr[d] && guard < 200) begin tick(); guard++; end
    chk("idle_timeout", 32'(guard < 200), 32'd1);
  endtask

  task automatic wait_done(input int d);
    int guard = 0;
    while (!done_w[d] && guard < 200) begin tick(); guard++; end
    chk("done_timeout", 32'(guard < 200), 32'd1);
  endtask

  // Plays one key through a whole sequence, checking every cycle against the model.
  task automatic run_key(input int d, input logic [3:0] code, input logic [3:0] c);
    int b = (d == 0) ? B0 : 0;
    int total = 2 * b + H + G;
    wait_idle(d);
    col_r[d] = c;
    kv[d] = 1'b1;
    kc[d] = code;
    tick();
    kv[d] = 1'b0;
    kc[d] = 4'($urandom);
    chk("accept_busy", 32'(busy_w[d]), 32'd1);
    chk("accept_ready", 32'(kr[d]), 32'd0);
    for (int j = 1; j <= total; j++) begin
      tick();
      chk("seq_row", 32'(row_w[d]), 32'(model_row(code, c, model_contact(j - 1, b))));
      chk("seq_busy", 32'(busy_w[d]), 32'(j < total));
      chk("seq_done", 32'(done_w[d]), 32'(j == total));
    end
    tick();
    chk("done_one_cycle", 32'(done_w[d]), 32'd0);
  endtask

  typedef struct {
    logic [3:0] code;
    logic [3:0] col;
    logic [3:0] row;
  } vec_t;

  vec_t vecs [21];

  initial begin
    vecs = '{
      '{4'h0, 4'b0111, 4'b1110}, '{4'h1, 4'b0111, 4'b0111}, '{4'h2, 4'b1011, 4'b0111},
      '{4'h3, 4'b1101, 4'b0111}, '{4'h4, 4'b0111, 4'b1011}, '{4'h5, 4'b1011, 4'b1011},
      '{4'h6, 4'b1101, 4'b1011}, '{4'h7, 4'b0111, 4'b1101}, '{4'h8, 4'b1011, 4'b1101},
      '{4'h9, 4'b1101, 4'b1101}, '{4'hA, 4'b1110, 4'b0111}, '{4'hB, 4'b1110, 4'b1011},
      '{4'hC, 4'b1110, 4'b1101}, '{4'hD, 4'b1110, 4'b1110}, '{4'hE, 4'b1101, 4'b1110},
      '{4'hF, 4'b1011, 4'b1110}, '{4'h5, 4'b0111, 4'b1111}, '{4'h5, 4'b0000, 4'b1011},
      '{4'hD, 4'b1111, 4'b1111}, '{4'h9, 4'b0101, 4'b1101}, '{4'hA, 4'b0001, 4'b1111}};

    rst = 2'b11;
    for (int d = 0; d < 2; d++) begin
      kv[d] = 1'b0; kc[d] = 4'h0; col_r[d] = 4'b1111;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_row", 32'(row_w[d]), 32'hF);
      chk("rst_ready", 32'(kr[d]), 32'd1);
      chk("rst_busy", 32'(busy_w[d]), 32'd0);
      chk("rst_done", 32'(done_w[d]), 32'd0);
    end
    rst = 2'b00;
    tick();

    // Row pattern in HOLD for every legend and several column drives.
    foreach (vecs[i]) begin
      wait_idle(1);
      col_r[1] = vecs[i].col; kc[1] = vecs[i].code; kv[1] = 1'b1;
      tick();
      kv[1] = 1'b0;
      tick();
      chk($sformatf("vec%0d_row", i), 32'(row_w[1]), 32'(vecs[i].row));
      wait_done(1);
      tick();
    end

    // Column drive moves during HOLD: row follows one cycle later.
    wait_idle(1);
    col_r[1] = 4'b1011; kc[1] = 4'h5; kv[1] = 1'b1;
    tick();
    kv[1] = 1'b0;
    tick();
    chk("hold_first_row", 32'(row_w[1]), 32'b1011);
    repeat (5) tick();
    chk("hold_mid_row", 32'(row_w[1]), 32'b1011);
    col_r[1] = 4'b0111;
    chk("col_change_latency", 32'(row_w[1]), 32'b1011);
    tick();
    chk("col_change_row", 32'(row_w[1]), 32'b1111);
    col_r[1] = 4'b1011;
    tick();
    chk("col_restore_row", 32'(row_w[1]), 32'b1011);
    wait_done(1);
    tick();

    // Asynchronous reset in HOLD abandons the key with no done pulse.
    wait_idle(1);
    col_r[1] = 4'b1011; kc[1] = 4'h5; kv[1] = 1'b1;
    tick();
    kv[1] = 1'b0;
    repeat (3) tick();
    chk("pre_rst_row", 32'(row_w[1]), 32'b1011);
    #2 rst[1] = 1'b1;
    #1;
    chk("midrst_row", 32'(row_w[1]), 32'hF);
    chk("midrst_ready", 32'(kr[1]), 32'd1);
    chk("midrst_busy", 32'(busy_w[1]), 32'd0);
    rst[1] = 1'b0;
    begin
      int seen = 0;
      for (int j = 0; j < 40; j++) begin tick(); seen += int'(done_w[1]); end
      chk("no_done_after_rst", 32'(seen), 32'd0);
    end

    // key_valid held high: second key taken in the done cycle, busy code ignored.
    wait_idle(1);
    col_r[1] = 4'b0000; kc[1] = 4'h2; kv[1] = 1'b1;
    tick();
    kc[1] = 4'h9;
    begin
      int n_done = 0, n_low = 0;
      for (int j = 1; j <= 2 * (H + G) + 1; j++) begin
        tick();
        n_done += int'(done_w[1]);
        n_low  += int'(!busy_w[1]);
        if (j == 10) chk("b2b_first_row", 32'(row_w[1]), 32'b0111);
        if (j == H + G + 1) kv[1] = 1'b0;
        if (j == H + G + 11) chk("b2b_second_row", 32'(row_w[1]), 32'b1101);
      end
      chk("b2b_done_count", 32'(n_done), 32'd2);
      chk("b2b_busy_low", 32'(n_low), 32'd2);
    end
    tick();

    // Bounce timing with every column driven low, then randomized keys and columns.
    run_key(0, 4'h1, 4'b0000);
    for (int k = 0; k < 10; k++) run_key(0, 4'($urandom), 4'($urandom));
    for (int k = 0; k < 4; k++) run_key(1, 4'($urandom), 4'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
